// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the 16-card memory game: reveals two cards per turn,
// compares symbols, removes or re-hides the pair, keeps scores and enforces
// a per-turn tick budget.
module memory_turn_ctrl #(
  parameter int unsigned TICK_DIV       = 50_000_000 / 10,
  parameter int unsigned TICKS_PER_TURN = 300,
  parameter int unsigned MISMATCH_HOLD  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        click_pulse,
  input  logic [3:0]  sel_idx,
  input  logic [47:0] board_syms,
  output logic [15:0] faceup_mask,
  output logic [15:0] removed_mask,
  output logic        current_player,
  output logic [3:0]  p1_pairs,
  output logic [3:0]  p2_pairs,
  output logic        show_winner,
  output logic [1:0]  winner,
  output logic [8:0]  ticks_left
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (MISMATCH_HOLD > 0) ? $clog2(MISMATCH_HOLD + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [8:0]    TURN_RELOAD = 9'(TICKS_PER_TURN);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(MISMATCH_HOLD);

  typedef enum logic [2:0] {
    IDLE,
    PICK1,
    PICK2,
    COMPARE,
    HOLD,
    GAME_OVER
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [3:0]      idx_a, idx_a_d, idx_b, idx_b_d;
  logic [15:0]     faceup_d, removed_d;
  logic            player_d;
  logic [3:0]      p1_d, p2_d;
  logic [8:0]      tl_d;
  logic [2:0]      syms [16];
  logic            valid_click;

  // Free-running game-tick prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Unpack the flat symbol bus into per-card entries.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      syms[i] = board_syms[3*i +: 3];
    end
  end

  assign valid_click = click_pulse && !faceup_mask[sel_idx] && !removed_mask[sel_idx];

  // State and game-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      faceup_mask    <= '0;
      removed_mask   <= '0;
      current_player <= 1'b0;
      p1_pairs       <= '0;
      p2_pairs       <= '0;
      ticks_left     <= TURN_RELOAD;
      hold_cnt       <= '0;
      idx_a          <= '0;
      idx_b          <= '0;
    end else begin
      state          <= state_d;
      faceup_mask    <= faceup_d;
      removed_mask   <= removed_d;
      current_player <= player_d;
      p1_pairs       <= p1_d;
      p2_pairs       <= p2_d;
      ticks_left     <= tl_d;
      hold_cnt       <= hold_d;
      idx_a          <= idx_a_d;
      idx_b          <= idx_b_d;
    end
  end

  // Next-state and next-data logic for the turn sequencer.
  always_comb begin
    state_d   = state;
    faceup_d  = faceup_mask;
    removed_d = removed_mask;
    player_d  = current_player;
    p1_d      = p1_pairs;
    p2_d      = p2_pairs;
    tl_d      = ticks_left;
    hold_d    = hold_cnt;
    idx_a_d   = idx_a;
    idx_b_d   = idx_b;

    case (state)
      IDLE: begin
        if (start_pulse) begin
          state_d  = PICK1;
          player_d = 1'b0;
          tl_d     = TURN_RELOAD;
        end
      end

      PICK1, PICK2: begin
        // Expiry takes priority over a click landing on the same cycle.
        if (tick && ticks_left == 9'd1) begin
          faceup_d = '0;
          player_d = ~current_player;
          tl_d     = TURN_RELOAD;
          state_d  = PICK1;
        end else begin
          if (tick) begin
            tl_d = ticks_left - 9'd1;
          end
          if (valid_click) begin
            faceup_d[sel_idx] = 1'b1;
            if (state == PICK1) begin
              idx_a_d = sel_idx;
              state_d = PICK2;
            end else begin
              idx_b_d = sel_idx;
              state_d = COMPARE;
            end
          end
        end
      end

      COMPARE: begin
        if (syms[idx_a] == syms[idx_b]) begin
          removed_d[idx_a] = 1'b1;
          removed_d[idx_b] = 1'b1;
          faceup_d[idx_a]  = 1'b0;
          faceup_d[idx_b]  = 1'b0;
          if (!current_player) begin
            if (p1_pairs != 4'd8) p1_d = p1_pairs + 4'd1;
          end else begin
            if (p2_pairs != 4'd8) p2_d = p2_pairs + 4'd1;
          end
          tl_d    = TURN_RELOAD;
          state_d = (&removed_d) ? GAME_OVER : PICK1;
        end else begin
          hold_d  = HOLD_RELOAD;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (tick) begin
          if (hold_cnt <= HW'(1)) begin
            hold_d          = '0;
            faceup_d[idx_a] = 1'b0;
            faceup_d[idx_b] = 1'b0;
            player_d        = ~current_player;
            tl_d            = TURN_RELOAD;
            state_d         = PICK1;
          end else begin
            hold_d = hold_cnt - HW'(1);
          end
        end
      end

      GAME_OVER: begin
        if (start_pulse) begin
          faceup_d  = '0;
          removed_d = '0;
          p1_d      = '0;
          p2_d      = '0;
          player_d  = 1'b0;
          tl_d      = TURN_RELOAD;
          state_d   = PICK1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Winner decode, only meaningful once the board is cleared.
  always_comb begin
    show_winner = (state == GAME_OVER);
    winner      = 2'b00;
    if (state == GAME_OVER) begin
      if (p1_pairs > p2_pairs)      winner = 2'b01;
      else if (p2_pairs > p1_pairs) winner = 2'b10;
      else                          winner = 2'b11;
    end
  end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: directed vector table, hand-written corner
// sequences and randomized clicking checked against a behavioural game model.
module tb_memory_turn_ctrl;

  localparam int TD  = 4;
  localparam int TPT = 5;
  localparam int MH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse;
  logic        click_pulse;
  logic [3:0]  sel_idx;
  logic [47:0] board_syms;
  logic [15:0] faceup_mask;
  logic [15:0] removed_mask;
  logic        current_player;
  logic [3:0]  p1_pairs;
  logic [3:0]  p2_pairs;
  logic        show_winner;
  logic [1:0]  winner;
  logic [8:0]  ticks_left;

  int checks   = 0;
  int failures = 0;

  memory_turn_ctrl #(
    .TICK_DIV(TD),
    .TICKS_PER_TURN(TPT),
    .MISMATCH_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_pulse(start_pulse),
    .click_pulse(click_pulse),
    .sel_idx(sel_idx),
    .board_syms(board_syms),
    .faceup_mask(faceup_mask),
    .removed_mask(removed_mask),
    .current_player(current_player),
    .p1_pairs(p1_pairs),
    .p2_pairs(p2_pairs),
    .show_winner(show_winner),
    .winner(winner),
    .ticks_left(ticks_left)
  );

  always #5 clk = ~clk;

  // Cards 2k and 2k+1 carry pair_sym[k].
  int pair_sym[8] = '{3, 1, 4, 0, 2, 5, 6, 7};

  function automatic int sym_of(input int c);
    return pair_sym[c / 2];
  endfunction

  // ---------------- behavioural game model ----------------
  bit        m_playing, m_over, m_judge;
  int        m_hold;
  int        m_shown[$];
  bit [15:0] m_removed;
  bit        m_player;
  int        m_p1, m_p2, m_tl, m_cnt;

  function automatic bit is_shown(input int c);
    foreach (m_shown[i]) if (m_shown[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_faceup();
    logic [15:0] f = '0;
    foreach (m_shown[i]) f[m_shown[i]] = 1'b1;
    return f;
  endfunction

  function automatic logic [1:0] m_winner();
    if (!m_over) return 2'b00;
    if (m_p1 > m_p2) return 2'b01;
    if (m_p2 > m_p1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit c, input int sel);
    bit tick;
    int a, b;
    if (r) begin
      m_playing = 0; m_over = 0; m_judge = 0; m_hold = 0;
      m_shown.delete(); m_removed = '0; m_player = 0;
      m_p1 = 0; m_p2 = 0; m_tl = TPT; m_cnt = 0;
      return;
    end
    tick = (m_cnt % TD) == TD - 1;
    m_cnt++;
    if (!m_playing) begin
      if (s) begin
        m_playing = 1; m_over = 0; m_removed = '0; m_p1 = 0; m_p2 = 0;
        m_player = 0; m_tl = TPT; m_shown.delete();
      end
    end else if (m_judge) begin
      m_judge = 0;
      a = m_shown[0];
      b = m_shown[1];
      if (sym_of(a) == sym_of(b)) begin
        m_removed[a] = 1'b1;
        m_removed[b] = 1'b1;
        m_shown.delete();
        if (!m_player) m_p1 = (m_p1 < 8) ? m_p1 + 1 : 8;
        else           m_p2 = (m_p2 < 8) ? m_p2 + 1 : 8;
        m_tl = TPT;
        if (m_removed == 16'hFFFF) begin
          m_playing = 0;
          m_over = 1;
        end
      end else begin
        m_hold = MH;
      end
    end else if (m_hold > 0) begin
      if (tick) begin
        m_hold--;
        if (m_hold == 0) begin
          m_shown.delete();
          m_player = !m_player;
          m_tl = TPT;
        end
      end
    end else begin
      if (tick && m_tl == 1) begin
        m_shown.delete();
        m_player = !m_player;
        m_tl = TPT;
      end else begin
        if (tick) m_tl--;
        if (c && !is_shown(sel) && !m_removed[sel]) begin
          m_shown.push_back(sel);
          if (m_shown.size() == 2) m_judge = 1;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit c, input int sel);
    rst = r; start_pulse = s; click_pulse = c; sel_idx = 4'(sel);
    @(posedge clk);
    model_step(r, s, c, sel);
    #1;
    chk("m_faceup",  faceup_mask,           m_faceup());
    chk("m_removed", removed_mask,          m_removed);
    chk("m_player",  16'(current_player),   16'(m_player));
    chk("m_p1",      16'(p1_pairs),         16'(m_p1));
    chk("m_p2",      16'(p2_pairs),         16'(m_p2));
    chk("m_ticks",   16'(ticks_left),       16'(m_tl));
    chk("m_show",    16'(show_winner),      16'(m_over));
    chk("m_winner",  16'(winner),           16'(m_winner()));
  endtask

  task automatic play_pair(input int k);
    cyc(0, 0, 1, 2 * k);
    cyc(0, 0, 1, 2 * k + 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic miss(input int a, input int b);
    int n;
    cyc(0, 0, 1, a);
    cyc(0, 0, 1, b);
    cyc(0, 0, 0, 0);
    n = 0;
    while ((m_hold > 0 || m_judge) && n < 40) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("hold_bound", 16'(m_hold), 16'd0);
  endtask

  typedef struct {
    bit s; bit c; int sel;
    int fu; int rm; int pl; int p1; int tl;
  } vec_t;

  vec_t tbl[16];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      board_syms[6*k +: 3]     = 3'(pair_sym[k]);
      board_syms[6*k + 3 +: 3] = 3'(pair_sym[k]);
    end

    // start/click, then expected faceup, removed, player, p1, ticks_left
    tbl[0]  = '{1, 0, 0, 'h00, 3, 0, 0, 5};
    tbl[0].rm = 0;
    tbl[1]  = '{0, 1, 0, 'h01, 0, 0, 0, 5};
    tbl[2]  = '{0, 1, 1, 'h03, 0, 0, 0, 5};
    tbl[3]  = '{0, 0, 0, 'h00, 3, 0, 1, 5};
    tbl[4]  = '{0, 1, 2, 'h04, 3, 0, 1, 5};
    tbl[5]  = '{0, 1, 5, 'h24, 3, 0, 1, 5};
    tbl[6]  = '{0, 0, 0, 'h24, 3, 0, 1, 5};
    tbl[7]  = '{0, 0, 0, 'h24, 3, 0, 1, 5};
    tbl[8]  = '{0, 1, 7, 'h24, 3, 0, 1, 5};
    tbl[9]  = '{1, 0, 0, 'h24, 3, 0, 1, 5};
    tbl[10] = '{0, 0, 0, 'h24, 3, 0, 1, 5};
    tbl[11] = '{0, 0, 0, 'h00, 3, 1, 1, 5};
    tbl[12] = '{0, 1, 0, 'h00, 3, 1, 1, 5};
    tbl[13] = '{0, 1, 4, 'h10, 3, 1, 1, 5};
    tbl[14] = '{0, 1, 4, 'h10, 3, 1, 1, 5};
    tbl[15] = '{0, 0, 0, 'h10, 3, 1, 1, 4};

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_faceup",  faceup_mask,         16'h0000);
    chk("rst_removed", removed_mask,        16'h0000);
    chk("rst_ticks",   16'(ticks_left),     16'd5);
    chk("rst_winner",  16'(winner),         16'd0);
    chk("rst_show",    16'(show_winner),    16'd0);

    // Directed vector table: match, mismatch hold, ignored clicks/starts
    for (int i = 0; i < 16; i++) begin
      cyc(0, tbl[i].s, tbl[i].c, tbl[i].sel);
      chk("tbl_faceup",  faceup_mask,           16'(tbl[i].fu));
      chk("tbl_removed", removed_mask,          16'(tbl[i].rm));
      chk("tbl_player",  16'(current_player),   16'(tbl[i].pl));
      chk("tbl_p1",      16'(p1_pairs),         16'(tbl[i].p1));
      chk("tbl_ticks",   16'(ticks_left),       16'(tbl[i].tl));
    end

    // Turn expiry with a valid click on the expiry cycle
    begin
      int n = 0;
      while (!(m_tl == 1 && (m_cnt % TD) == TD - 1) && n < 100) begin
        cyc(0, 0, 0, 0);
        n++;
      end
      chk("expiry_bound", 16'(n < 100), 16'd1);
      cyc(0, 0, 1, 6);
      chk("expiry_faceup", faceup_mask,         16'h0000);
      chk("expiry_player", 16'(current_player), 16'd0);
      chk("expiry_ticks",  16'(ticks_left),     16'd5);
      cyc(0, 0, 1, 6);
      chk("post_expiry_click", faceup_mask,     16'h0040);
    end

    // Full game: P1 5 pairs, P2 3 pairs
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) play_pair(k);
    miss(10, 12);
    chk("g1_turn", 16'(current_player), 16'd1);
    for (int k = 5; k < 8; k++) play_pair(k);
    chk("g1_show",   16'(show_winner), 16'd1);
    chk("g1_winner", 16'(winner),      16'b01);
    chk("g1_p1",     16'(p1_pairs),    16'd5);
    chk("g1_p2",     16'(p2_pairs),    16'd3);

    // Restart from GAME_OVER, then a 4/4 tie
    cyc(0, 1, 0, 0);
    chk("restart_removed", removed_mask,         16'h0000);
    chk("restart_p1",      16'(p1_pairs),        16'd0);
    chk("restart_player",  16'(current_player),  16'd0);
    chk("restart_show",    16'(show_winner),     16'd0);
    for (int k = 0; k < 4; k++) play_pair(k);
    miss(8, 10);
    for (int k = 4; k < 8; k++) play_pair(k);
    chk("g2_winner", 16'(winner), 16'b11);

    // Reset while holding a mismatch
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold_faceup", faceup_mask, 16'h0005);
    cyc(1, 0, 0, 0);
    chk("hrst_faceup",  faceup_mask,         16'h0000);
    chk("hrst_removed", removed_mask,        16'h0000);
    chk("hrst_p1",      16'(p1_pairs),       16'd0);
    chk("hrst_ticks",   16'(ticks_left),     16'd5);
    chk("hrst_winner",  16'(winner),         16'd0);
    cyc(0, 0, 1, 3);
    chk("idle_click", faceup_mask, 16'h0000);

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) == 0,
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
